// File: rtl/dut_vec_pkg.sv
// Shared types and constants for the multi-channel vector engine.
package dut_vec_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      APPLY = 3'd2,
      EVAL  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_e;

   // Capture modes; the unused encoding 3 behaves like capture-all.
   localparam logic [1:0] MODE_CAPTURE_ALL  = 2'd0;
   localparam logic [1:0] MODE_COMPARE      = 2'd1;
   localparam logic [1:0] MODE_CAPTURE_FAIL = 2'd2;

   // Stimulus word layout: {cycles, stimulus}; cycles field sits above the stimulus.
   localparam int DEF_STF_WIDTH   = 24;
   localparam int DEF_CYCLE_RANGE = 5;
   localparam int CYC_FIELD_LSB   = DEF_STF_WIDTH;
   localparam int CYC_FIELD_W     = DEF_CYCLE_RANGE + 1;

   // Modes that consume expected data and can flag a failure.
   function automatic logic mode_compares(input logic [1:0] m);
      return (m == MODE_COMPARE) || (m == MODE_CAPTURE_FAIL);
   endfunction

endpackage

// File: rtl/chan_mux.sv
// Registered stimulus demux onto the channel buses plus response slice select.
module chan_mux #(
   parameter int CHANNELS   = 4,
   parameter int CSEL_WIDTH = 2,
   parameter int STF_WIDTH  = 24,
   parameter int RTF_WIDTH  = 24
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          load,
   input  logic [CSEL_WIDTH-1:0]         sel,
   input  logic [STF_WIDTH-1:0]          stim,
   input  logic [CHANNELS*RTF_WIDTH-1:0] miso,
   output logic [CHANNELS*STF_WIDTH-1:0] mosi,
   output logic [RTF_WIDTH-1:0]          resp
);

   logic [CSEL_WIDTH-1:0]                sel_q;
   logic [CHANNELS-1:0][STF_WIDTH-1:0]   mosi_a;
   logic [CHANNELS-1:0][RTF_WIDTH-1:0]   miso_a;

   assign miso_a = miso;
   assign mosi   = mosi_a;

   // On load, drive only the selected lane; an out-of-range select blanks all lanes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q  <= '0;
         mosi_a <= '0;
      end else if (load) begin
         sel_q <= sel;
         for (int c = 0; c < CHANNELS; c++)
            mosi_a[c] <= (int'(sel) == c) ? stim : '0;
      end
   end

   // Response comes from the lane latched at load; out-of-range reads as zero.
   always_comb begin
      resp = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (int'(sel_q) == c) resp = miso_a[c];
   end

endmodule

// File: rtl/dut_vector_engine.sv
// Pops stimulus vectors, drives one target channel for a per-vector cycle
// count, samples the response, optionally compares it and pushes results.
module dut_vector_engine
   import dut_vec_pkg::*;
#(
   parameter int STF_WIDTH   = DEF_STF_WIDTH,
   parameter int RTF_WIDTH   = 24,
   parameter int CYCLE_RANGE = DEF_CYCLE_RANGE,
   parameter int CHANNELS    = 4,
   parameter int CSEL_WIDTH  = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              enable,
   input  logic [1:0]                        mode,
   input  logic [CSEL_WIDTH-1:0]             chan_sel,
   input  logic                              clear,
   output logic                              busy,
   input  logic [STF_WIDTH+CYCLE_RANGE:0]    sfifo_data,
   input  logic                              sfifo_rdempty,
   output logic                              sfifo_rdreq,
   input  logic [2*RTF_WIDTH-1:0]            efifo_data,
   input  logic                              efifo_rdempty,
   output logic                              efifo_rdreq,
   output logic [RTF_WIDTH:0]                rfifo_data,
   output logic                              rfifo_wrreq,
   input  logic                              rfifo_wrfull,
   output logic [CHANNELS*STF_WIDTH-1:0]     mosi,
   input  logic [CHANNELS*RTF_WIDTH-1:0]     miso,
   output logic [CNT_WIDTH-1:0]              vector_count,
   output logic [CNT_WIDTH-1:0]              mismatch_count
);

   localparam int CYC_W = CYCLE_RANGE + 1;

   state_e               state;
   logic [CYC_W-1:0]     cnt;
   logic [CYC_W-1:0]     cyc_in;
   logic [RTF_WIDTH-1:0] exp_q, mask_q, resp_q, miso_sel;
   logic [1:0]           mode_q;
   logic                 start_ok, fail, wr_need, load;

   assign cyc_in      = sfifo_data[STF_WIDTH +: CYC_W];
   assign start_ok    = enable && !sfifo_rdempty && (!mode_compares(mode) || !efifo_rdempty);
   assign fail        = mode_compares(mode_q) && (|((resp_q ^ exp_q) & mask_q));
   assign wr_need     = (mode_q == MODE_CAPTURE_FAIL) ? fail : (mode_q != MODE_COMPARE);
   assign load        = (state == LOAD);
   assign busy        = (state != IDLE);
   assign rfifo_wrreq = (state == WRITE) && !rfifo_wrfull;

   chan_mux #(
      .CHANNELS   (CHANNELS),
      .CSEL_WIDTH (CSEL_WIDTH),
      .STF_WIDTH  (STF_WIDTH),
      .RTF_WIDTH  (RTF_WIDTH)
   ) u_mux (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .sel     (chan_sel),
      .stim    (sfifo_data[STF_WIDTH-1:0]),
      .miso    (miso),
      .mosi    (mosi),
      .resp    (miso_sel)
   );

   // Vector sequencer: pops are issued one cycle ahead as LOAD is entered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sfifo_rdreq <= 1'b0;
         efifo_rdreq <= 1'b0;
         cnt         <= '0;
         exp_q       <= '0;
         mask_q      <= '0;
         resp_q      <= '0;
         mode_q      <= '0;
         rfifo_data  <= '0;
      end else begin
         sfifo_rdreq <= 1'b0;
         efifo_rdreq <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state       <= LOAD;
                  sfifo_rdreq <= 1'b1;
                  efifo_rdreq <= mode_compares(mode);
               end else begin
                  state <= IDLE;
               end
            end
            LOAD: begin
               // A zero cycle count still applies the vector for one cycle.
               cnt    <= (cyc_in == '0) ? '0 : cyc_in - CYC_W'(1);
               exp_q  <= efifo_data[RTF_WIDTH-1:0];
               mask_q <= efifo_data[2*RTF_WIDTH-1:RTF_WIDTH];
               mode_q <= mode;
               state  <= APPLY;
            end
            APPLY: begin
               if (cnt == '0) begin
                  resp_q <= miso_sel;
                  state  <= EVAL;
               end else begin
                  cnt <= cnt - CYC_W'(1);
               end
            end
            EVAL: begin
               rfifo_data <= {fail, resp_q};
               state      <= wr_need ? WRITE : DONE;
            end
            WRITE: if (!rfifo_wrfull) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Completion counters; clear takes priority over a same-cycle increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vector_count   <= '0;
         mismatch_count <= '0;
      end else if (clear) begin
         vector_count   <= '0;
         mismatch_count <= '0;
      end else if (state == EVAL) begin
         vector_count <= vector_count + CNT_WIDTH'(1);
         if (fail && (mismatch_count != '1))
            mismatch_count <= mismatch_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_dut_vector_engine.sv
// Randomized and directed bench for dut_vector_engine with a result scoreboard.
module tb_dut_vector_engine;

   localparam int STF = 24;
   localparam int RTF = 24;
   localparam int CR  = 5;
   localparam int CH  = 3;
   localparam int CS  = 2;
   localparam int CW  = 4;
   localparam int SW  = STF + CR + 1;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              enable = 1'b0;
   logic              clear = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [CS-1:0]     chan_sel = '0;
   logic              busy;
   logic [SW-1:0]     sfifo_data;
   logic              sfifo_rdempty, sfifo_rdreq;
   logic [2*RTF-1:0]  efifo_data;
   logic              efifo_rdempty, efifo_rdreq;
   logic [RTF:0]      rfifo_data;
   logic              rfifo_wrreq, rfifo_wrfull;
   logic [CH*STF-1:0] mosi;
   logic [CH*RTF-1:0] miso = '0;
   logic [CW-1:0]     vector_count, mismatch_count;

   // FIFO models: show-ahead arrays with free-running pointers
   logic [SW-1:0]    smem [256];
   logic [CS-1:0]    schan[256];
   logic [2*RTF-1:0] emem [256];
   int s_wr = 0, s_rd = 0, e_wr = 0, e_rd = 0;

   assign sfifo_data    = smem[s_rd[7:0]];
   assign sfifo_rdempty = (s_rd == s_wr);
   assign efifo_data    = emem[e_rd[7:0]];
   assign efifo_rdempty = (e_rd == e_wr);

   logic force_full = 1'b0, rnd_full = 1'b0, rnd_bit = 1'b0;
   assign rfifo_wrfull = rnd_full ? rnd_bit : force_full;

   always #5 clock = ~clock;

   dut_vector_engine #(
      .STF_WIDTH(STF), .RTF_WIDTH(RTF), .CYCLE_RANGE(CR),
      .CHANNELS(CH), .CSEL_WIDTH(CS), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
      .chan_sel(chan_sel), .clear(clear), .busy(busy),
      .sfifo_data(sfifo_data), .sfifo_rdempty(sfifo_rdempty), .sfifo_rdreq(sfifo_rdreq),
      .efifo_data(efifo_data), .efifo_rdempty(efifo_rdempty), .efifo_rdreq(efifo_rdreq),
      .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
      .mosi(mosi), .miso(miso),
      .vector_count(vector_count), .mismatch_count(mismatch_count)
   );

   int total = 0, bad = 0;
   int wr_cnt = 0;
   int mdl_vc = 0, mdl_mc = 0;
   logic [RTF:0]      exp_res[$];
   logic [CH*STF-1:0] mosi_exp = '0;
   logic [SW-1:0]     pop_w;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
      end
   endtask

   // Response the spec says the engine samples for the current channel and miso
   function automatic logic [RTF-1:0] model_resp();
      if (int'(chan_sel) < CH) return miso[int'(chan_sel)*RTF +: RTF];
      return '0;
   endfunction

   // Queue one vector and predict its outcome at the transaction level
   task automatic push_vec(input logic [CR:0] cyc, input logic [STF-1:0] stim,
                           input logic [RTF-1:0] expd, input logic [RTF-1:0] msk);
      logic [RTF-1:0] r;
      logic f;
      logic cmp;
      r   = model_resp();
      cmp = (mode == 2'd1) || (mode == 2'd2);
      smem[s_wr[7:0]]  = {cyc, stim};
      schan[s_wr[7:0]] = chan_sel;
      s_wr++;
      if (cmp) begin
         emem[e_wr[7:0]] = {msk, expd};
         e_wr++;
      end
      f = cmp && (((r ^ expd) & msk) != '0);
      if (mode == 2'd0 || mode == 2'd3 || (mode == 2'd2 && f)) exp_res.push_back({f, r});
      mdl_vc = (mdl_vc + 1) % 16;
      if (f && mdl_mc < 15) mdl_mc++;
   endtask

   // Posedge monitor: FIFO pops, result scoreboard, protocol rules
   always @(posedge clock) begin
      if (!reset_n) begin
         mosi_exp = '0;
      end else begin
         chk("s_pop_empty", 128'(sfifo_rdreq & sfifo_rdempty), 128'(0));
         chk("e_pop_empty", 128'(efifo_rdreq & efifo_rdempty), 128'(0));
         chk("wr_on_full", 128'(rfifo_wrreq & rfifo_wrfull), 128'(0));
         if (rfifo_wrreq && !rfifo_wrfull) begin
            wr_cnt++;
            chk("wr_expected", 128'(exp_res.size() != 0), 128'(1));
            if (exp_res.size() != 0) chk("wr_data", 128'(rfifo_data), 128'(exp_res.pop_front()));
         end
         if (sfifo_rdreq && !sfifo_rdempty) begin
            pop_w = smem[s_rd[7:0]];
            for (int c = 0; c < CH; c++)
               mosi_exp[c*STF +: STF] = (int'(schan[s_rd[7:0]]) == c) ? pop_w[STF-1:0] : '0;
            s_rd <= s_rd + 1;
         end
         if (efifo_rdreq && !efifo_rdempty) e_rd <= e_rd + 1;
      end
   end

   // Negedge monitor: mosi must hold the last loaded pattern at all times
   always @(negedge clock) begin
      rnd_bit = ($urandom_range(0, 2) == 0);
      if (reset_n) chk("mosi", 128'(mosi), 128'(mosi_exp));
   end

   task automatic wait_load();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (sfifo_rdreq) begin ok = 1; break; end
      end
      chk("load_timeout", 128'(ok), 128'(1));
   endtask

   task automatic wait_notbusy();
      bit ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         if (!busy) begin ok = 1; break; end
      end
      chk("busy_timeout", 128'(ok), 128'(1));
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clock);
         if (sfifo_rdempty && !busy) begin ok = 1; break; end
      end
      chk("idle_timeout", 128'(ok), 128'(1));
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_vc"}, 128'(vector_count), 128'(mdl_vc));
      chk({tag, "_mc"}, 128'(mismatch_count), 128'(mdl_mc));
      chk({tag, "_pending"}, 128'(exp_res.size()), 128'(0));
      chk({tag, "_e_left"}, 128'(e_wr - e_rd), 128'(0));
   endtask

   task automatic drain(input string tag);
      enable = 1'b1;
      wait_idle();
      enable = 1'b0;
      check_counts(tag);
   endtask

   task automatic do_clear();
      @(negedge clock) clear = 1'b1;
      @(negedge clock) clear = 1'b0;
      mdl_vc = 0;
      mdl_mc = 0;
      chk("clr_vc", 128'(vector_count), 128'(0));
      chk("clr_mc", 128'(mismatch_count), 128'(0));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [RTF-1:0] r;
      logic [RTF-1:0] expd, msk;
      int w0, s0, prev_vc, n;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_srd", 128'(sfifo_rdreq), 128'(0));
      chk("rst_erd", 128'(efifo_rdreq), 128'(0));
      chk("rst_wr", 128'(rfifo_wrreq), 128'(0));
      chk("rst_rdata", 128'(rfifo_data), 128'(0));
      chk("rst_mosi", 128'(mosi), 128'(0));
      chk("rst_vc", 128'(vector_count), 128'(0));
      chk("rst_mc", 128'(mismatch_count), 128'(0));
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Mode 0, channel 2, 3 apply cycles
      mode = 2'd0; chan_sel = 2'd2;
      miso = 72'({$urandom, $urandom, $urandom});
      miso[2*RTF +: RTF] = 24'h123456;
      push_vec(6'd3, 24'hA5A5A5, '0, '0);
      enable = 1'b1;
      wait_load();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("a_mosi2", 128'(mosi[71:48]), 128'(24'hA5A5A5));
         chk("a_mosi_lo", 128'(mosi[47:0]), 128'(0));
         chk("a_apply_wr", 128'(rfifo_wrreq), 128'(0));
      end
      @(negedge clock);
      chk("a_eval_vc", 128'(vector_count), 128'(0));
      chk("a_eval_wr", 128'(rfifo_wrreq), 128'(0));
      @(negedge clock);
      chk("a_wr", 128'(rfifo_wrreq), 128'(1));
      chk("a_data", 128'(rfifo_data), 128'({1'b0, 24'h123456}));
      chk("a_vc", 128'(vector_count), 128'(1));
      wait_notbusy();
      check_counts("a");

      // Mode 2: one passing and one failing vector
      do_clear();
      mode = 2'd2; chan_sel = 2'd1;
      miso = 72'({$urandom, $urandom, $urandom});
      r = model_resp();
      w0 = wr_cnt;
      push_vec(6'd1, 24'($urandom), r, 24'hFFFFFF);
      push_vec(6'd2, 24'($urandom), r ^ 24'h000001, 24'hFFFFFF);
      drain("m2");
      chk("m2_writes", 128'(wr_cnt - w0), 128'(1));
      chk("m2_mc1", 128'(mismatch_count), 128'(1));
      chk("m2_vc2", 128'(vector_count), 128'(2));

      // Mode 1: differences only outside the mask
      mode = 2'd1; chan_sel = 2'd0;
      r = model_resp();
      w0 = wr_cnt;
      push_vec(6'd2, 24'($urandom), r ^ 24'hABCD00, 24'h0000FF);
      drain("m1");
      chk("m1_writes", 128'(wr_cnt - w0), 128'(0));
      chk("m1_mc", 128'(mismatch_count), 128'(1));

      // cycles=0 with the result FIFO full for five cycles
      mode = 2'd0; chan_sel = 2'd1;
      prev_vc = mdl_vc;
      push_vec(6'd0, 24'($urandom), '0, '0);
      force_full = 1'b1;
      enable = 1'b1;
      wait_load();
      enable = 1'b0;
      @(negedge clock);
      chk("f_apply_wr", 128'(rfifo_wrreq), 128'(0));
      @(negedge clock);
      chk("f_eval_vc", 128'(vector_count), 128'(prev_vc));
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("f_vc", 128'(vector_count), 128'(mdl_vc));
         chk("f_stall_wr", 128'(rfifo_wrreq), 128'(0));
         chk("f_stall_busy", 128'(busy), 128'(1));
      end
      force_full = 1'b0;
      #1;
      chk("f_release_wr", 128'(rfifo_wrreq), 128'(1));
      wait_notbusy();
      check_counts("f");

      // Enable dropped during APPLY of the first of three vectors
      mode = 2'd0; chan_sel = 2'd2;
      s0 = s_rd; w0 = wr_cnt;
      for (int i = 0; i < 3; i++) push_vec(6'd4, 24'($urandom), '0, '0);
      enable = 1'b1;
      wait_load();
      @(negedge clock);
      enable = 1'b0;
      wait_notbusy();
      repeat (5) @(negedge clock);
      chk("ed_pops", 128'(s_rd - s0), 128'(1));
      chk("ed_left", 128'(s_wr - s_rd), 128'(2));
      chk("ed_writes", 128'(wr_cnt - w0), 128'(1));
      chk("ed_pending", 128'(exp_res.size()), 128'(2));
      chk("ed_busy", 128'(busy), 128'(0));
      drain("ed");

      // Asynchronous reset during APPLY: no write, everything back to zero
      mode = 2'd0; chan_sel = 2'd0;
      push_vec(6'd5, 24'($urandom), '0, '0);
      w0 = wr_cnt;
      enable = 1'b1;
      wait_load();
      enable = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_busy", 128'(busy), 128'(0));
      chk("ar_mosi", 128'(mosi), 128'(0));
      chk("ar_wr", 128'(rfifo_wrreq), 128'(0));
      chk("ar_vc", 128'(vector_count), 128'(0));
      exp_res.delete();
      mdl_vc = 0; mdl_mc = 0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      chk("ar_nowrite", 128'(wr_cnt - w0), 128'(0));
      check_counts("ar");

      // Randomized batches with a randomly back-pressured result FIFO
      rnd_full = 1'b1;
      for (int b = 0; b < 10; b++) begin
         mode     = 2'($urandom_range(0, 3));
         chan_sel = CS'($urandom_range(0, 3));
         miso     = 72'({$urandom, $urandom, $urandom});
         r        = model_resp();
         n        = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
               0:       expd = r;
               1:       expd = r ^ (24'h1 << $urandom_range(0, 23));
               default: expd = 24'($urandom);
            endcase
            msk = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom);
            push_vec(($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4)),
                     24'($urandom), expd, msk);
         end
         drain("rnd");
      end
      rnd_full = 1'b0;

      // Counter boundaries: wrap of vector_count, saturation of mismatch_count
      do_clear();
      mode = 2'd2; chan_sel = 2'd1;
      miso = 72'({$urandom, $urandom, $urandom});
      r = model_resp();
      for (int i = 0; i < 16; i++) push_vec(6'd0, 24'($urandom), r ^ 24'h000001, 24'hFFFFFF);
      drain("sat");
      chk("sat_mc", 128'(mismatch_count), 128'(4'hF));
      chk("wrap_vc", 128'(vector_count), 128'(0));
      for (int i = 0; i < 2; i++) push_vec(6'd0, 24'($urandom), r ^ 24'h000100, 24'hFFFFFF);
      drain("sat2");
      chk("sat2_mc", 128'(mismatch_count), 128'(4'hF));

      // clear coinciding with the EVAL increment
      push_vec(6'd0, 24'($urandom), r ^ 24'h800000, 24'hFFFFFF);
      enable = 1'b1;
      wait_load();
      enable = 1'b0;
      @(negedge clock);
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      mdl_vc = 0; mdl_mc = 0;
      chk("ce_vc", 128'(vector_count), 128'(0));
      chk("ce_mc", 128'(mismatch_count), 128'(0));
      wait_notbusy();
      check_counts("ce");

      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
